// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and its stall/flush sequencer.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  // Hazard sources observed in the pipeline
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdE;
  logic [2:0]       ResultSrcE;
  logic             PCSrcE;
  logic             mdv_opE;
  logic             mdv_done;
  logic             dmem_reqM;
  logic             dmem_ready;

  // Pipeline register controls
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             KillW;
  logic             mdv_start;

  // Status and performance counter
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: reports hazards, consumes controls
  modport master (
    output Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, mdv_opE, mdv_done, dmem_reqM, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, KillW, mdv_start,
    input  state, stall_cycles
  );

  // Sequencer side
  modport slave (
    input  Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, mdv_opE, mdv_done, dmem_reqM, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, KillW, mdv_start,
    output state, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, taken branch,
// data-memory wait states and multi-cycle mul/div, plus a stall-cycle counter.
module pipeline_ctrl #(
  parameter logic [2:0]  LOAD_SRC = 3'b001,
  parameter int unsigned CNT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMdvWait = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic lu_haz;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem;
  logic kill_wb, mdv_start;

  assign mem_stall = bus.dmem_reqM & ~bus.dmem_ready;
  assign lu_haz    = (bus.ResultSrcE == LOAD_SRC) && (bus.RdE != 5'd0) &&
                     ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // Prioritised hazard resolution: next state and same-cycle pipeline controls
  always_comb begin
    state_d   = state_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    kill_wb   = 1'b0;
    mdv_start = 1'b0;

    if (!reset) begin
      if (mem_stall && (state_q != StMdvWait)) begin
        // Freeze everything; a branch or mul/div in EX waits for the release
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        kill_wb   = 1'b1;
        state_d   = StMemWait;
      end else if (state_q == StMdvWait) begin
        // MEM holds a bubble here, so any mem_stall is spurious and ignored
        if (bus.mdv_done) begin
          state_d = StRun;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          flush_mem = 1'b1;
        end
      end else begin
        // RUN, or the release cycle of MEM_WAIT: deferred EX hazards resolve now
        // so the mul/div or branch held in EX is not lost when EX/MEM advances.
        state_d = StRun;
        if (bus.mdv_opE) begin
          mdv_start = 1'b1;
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          flush_mem = 1'b1;
          state_d   = StMdvWait;
        end else if (bus.PCSrcE) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (lu_haz) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  // Performance counter counts every fetch-stall cycle, wrapping naturally
  always_comb begin
    cnt_d = cnt_q;
    if (stall_if) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.StallF       = stall_if;
  assign bus.StallD       = stall_id;
  assign bus.StallE       = stall_ex;
  assign bus.StallM       = stall_mem;
  assign bus.FlushD       = flush_id;
  assign bus.FlushE       = flush_ex;
  assign bus.FlushM       = flush_mem;
  assign bus.KillW        = kill_wb;
  assign bus.mdv_start    = mdv_start;
  assign bus.state        = state_q;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Inputs change 1ns after posedge; outputs
// are sampled on negedge. Control vector order:
// {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, KillW, mdv_start}.
module tb_pipeline_ctrl;

  localparam logic [8:0] CtlNone   = 9'b000000000;
  localparam logic [8:0] CtlLu     = 9'b110001000;
  localparam logic [8:0] CtlBr     = 9'b000011000;
  localparam logic [8:0] CtlMdvGo  = 9'b111000101;
  localparam logic [8:0] CtlMdvHld = 9'b111000100;
  localparam logic [8:0] CtlMem    = 9'b111100010;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(
    .LOAD_SRC (3'b001),
    .CNT_W    (32)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [8:0] ctl;
  assign ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                bus.FlushD, bus.FlushE, bus.FlushM, bus.KillW, bus.mdv_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mdv_done must never coincide with mdv_start
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.mdv_start && bus.mdv_done))
        else $error("mdv_done coincides with mdv_start");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.Rs1D       = 5'd0;
    bus.Rs2D       = 5'd0;
    bus.RdE        = 5'd0;
    bus.ResultSrcE = 3'd0;
    bus.PCSrcE     = 1'b0;
    bus.mdv_opE    = 1'b0;
    bus.mdv_done   = 1'b0;
    bus.dmem_reqM  = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    set_idle();
    reset = 1'b1;
    // Hazards presented during reset must not reach the outputs
    bus.mdv_opE = 1'b1;
    bus.PCSrcE  = 1'b1;
    sample();
    check_eq("reset_ctl", 32'(ctl), 32'(CtlNone));
    next_cycle();
    set_idle();
    next_cycle();
    reset = 1'b0;
    sample();
    check_eq("reset_state", 32'(bus.state), 32'd0);
    check_eq("reset_cnt", bus.stall_cycles, 32'd0);
    check_eq("idle_ctl", 32'(ctl), 32'(CtlNone));

    // Load-use on Rs1
    next_cycle();
    bus.ResultSrcE = 3'b001; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
    sample();
    check_eq("lu_rs1_ctl", 32'(ctl), 32'(CtlLu));
    next_cycle();
    set_idle();
    sample();
    check_eq("lu_after_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("lu_cnt", bus.stall_cycles, 32'd1);
    // Load to x0 is not a hazard
    next_cycle();
    bus.ResultSrcE = 3'b001; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    sample();
    check_eq("lu_x0_ctl", 32'(ctl), 32'(CtlNone));
    // Load-use on Rs2
    next_cycle();
    bus.ResultSrcE = 3'b001; bus.RdE = 5'd7; bus.Rs1D = 5'd1; bus.Rs2D = 5'd7;
    sample();
    check_eq("lu_rs2_ctl", 32'(ctl), 32'(CtlLu));
    // Matching register but not a load
    next_cycle();
    bus.ResultSrcE = 3'b000;
    sample();
    check_eq("nonload_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("lu2_cnt", bus.stall_cycles, 32'd2);

    // Taken branch overrides load-use
    next_cycle();
    set_idle();
    bus.PCSrcE = 1'b1; bus.ResultSrcE = 3'b001; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
    sample();
    check_eq("br_ctl", 32'(ctl), 32'(CtlBr));
    next_cycle();
    set_idle();
    sample();
    check_eq("br_after_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("br_cnt", bus.stall_cycles, 32'd2);

    // Mul/div with done 4 cycles after start
    next_cycle();
    bus.mdv_opE = 1'b1;
    sample();
    check_eq("mdv_t0_ctl", 32'(ctl), 32'(CtlMdvGo));
    check_eq("mdv_t0_state", 32'(bus.state), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      sample();
      check_eq($sformatf("mdv_t%0d_ctl", i), 32'(ctl), 32'(CtlMdvHld));
      check_eq($sformatf("mdv_t%0d_state", i), 32'(bus.state), 32'd1);
    end
    next_cycle();
    bus.mdv_done = 1'b1;
    sample();
    check_eq("mdv_t4_ctl", 32'(ctl), 32'(CtlNone));
    next_cycle();
    set_idle();
    sample();
    check_eq("mdv_end_state", 32'(bus.state), 32'd0);
    check_eq("mdv_end_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("mdv_cnt", bus.stall_cycles, 32'd6);

    // Memory wait, ready low for 3 cycles
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      bus.dmem_reqM = 1'b1; bus.dmem_ready = 1'b0;
      sample();
      check_eq($sformatf("mem_w%0d_ctl", i), 32'(ctl), 32'(CtlMem));
    end
    check_eq("mem_wait_state", 32'(bus.state), 32'd2);
    next_cycle();
    bus.dmem_ready = 1'b1;
    sample();
    check_eq("mem_rel_ctl", 32'(ctl), 32'(CtlNone));
    next_cycle();
    set_idle();
    sample();
    check_eq("mem_end_state", 32'(bus.state), 32'd0);
    check_eq("mem_cnt", bus.stall_cycles, 32'd9);

    // Branch during memory wait is deferred to the release cycle
    next_cycle();
    bus.dmem_reqM = 1'b1; bus.PCSrcE = 1'b1;
    sample();
    check_eq("mem_br_wait_ctl", 32'(ctl), 32'(CtlMem));
    next_cycle();
    bus.dmem_ready = 1'b1;
    sample();
    check_eq("mem_br_rel_ctl", 32'(ctl), 32'(CtlBr));

    // Memory wait with mul/div pending for 2 cycles
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      set_idle();
      bus.dmem_reqM = 1'b1; bus.mdv_opE = 1'b1;
      sample();
      check_eq($sformatf("memmdv_w%0d_ctl", i), 32'(ctl), 32'(CtlMem));
    end
    next_cycle();
    bus.dmem_ready = 1'b1;
    sample();
    check_eq("memmdv_rel_ctl", 32'(ctl), 32'(CtlMdvGo));
    next_cycle();
    set_idle();
    bus.mdv_opE = 1'b1;
    sample();
    check_eq("memmdv_wait_state", 32'(bus.state), 32'd1);
    check_eq("memmdv_wait_ctl", 32'(ctl), 32'(CtlMdvHld));
    check_eq("memmdv_cnt", bus.stall_cycles, 32'd13);

    // Reset in the middle of MDV_WAIT
    next_cycle();
    reset = 1'b1;
    sample();
    check_eq("rst_mid_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("rst_mid_cnt", bus.stall_cycles, 32'd14);
    next_cycle();
    sample();
    check_eq("rst_hold_state", 32'(bus.state), 32'd0);
    check_eq("rst_hold_cnt", bus.stall_cycles, 32'd0);
    next_cycle();
    reset = 1'b0;
    set_idle();
    bus.mdv_done = 1'b1;
    sample();
    check_eq("late_done_ctl", 32'(ctl), 32'(CtlNone));
    next_cycle();
    set_idle();
    sample();
    check_eq("late_done_state", 32'(bus.state), 32'd0);
    check_eq("late_done_cnt", bus.stall_cycles, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the hold and clear controls of the IF, IF/ID, ID/EX and EX/MEM pipeline registers, and it suppresses write-back into MEM/WB. It resolves load-use hazards, taken branches/jumps, data-memory wait states and the multi-cycle mul/div unit through a small FSM. It also keeps a stall-cycle counter for performance monitoring.

## Interface
- Parameters:
- LOAD_SRC, 3'b001: ResultSrcE encoding that marks a load in EX.
- CNT_W, 32: width of stall_cycles.
- Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers in ID.
- RdE  in  5  destination register in EX.
- ResultSrcE  in  3  result select of the EX instruction.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- mdv_opE  in  1  EX holds a multi-cycle mul/div instruction.
- mdv_done  in  1  one-cycle pulse from the mul/div unit when its result is valid.
- dmem_reqM  in  1  MEM holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold IF, IF/ID, ID/EX and EX/MEM. Integration drives en = ~Stall*.
- FlushD, FlushE, FlushM  out  1 each  clear IF/ID, ID/EX and EX/MEM to a bubble. Integration ORs each with reset.
- KillW  out  1  forces RegWriteM to 0 at the MEM/WB input, because that register has no enable.
- mdv_start  out  1  one-cycle start pulse to the mul/div unit.
- state  out  2  FSM state: 0 RUN, 1 MDV_WAIT, 2 MEM_WAIT.
- stall_cycles  out  CNT_W  count of cycles with StallF=1; wraps modulo 2^CNT_W.

## Operation
- Definitions:
- mem_stall = dmem_reqM & ~dmem_ready.
- lu_haz = (ResultSrcE==LOAD_SRC) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- Priority, highest first, evaluated every cycle.
- 1. mem_stall, in any state other than MDV_WAIT:
  - Assert StallF/D/E/M and KillW.
  - No flushes, no mdv_start; a pending PCSrcE is deferred, not lost.
  - The next state is MEM_WAIT.
  - When dmem_ready arrives, all outputs deassert and the state returns to RUN.
- 2. RUN & mdv_opE:
  - Assert mdv_start and StallF/D/E and FlushM.
  - The next state is MDV_WAIT.
- 3. MDV_WAIT & ~mdv_done: assert StallF/D/E and FlushM; mdv_start=0.
- 4. MDV_WAIT & mdv_done:
  - No stalls; EX/MEM captures the result.
  - The next state is RUN.
  - The still-present mdv_opE is not re-issued this cycle.
- 5. PCSrcE: assert FlushD and FlushE. This overrides lu_haz, so StallF/StallD stay 0.
- 6. lu_haz: assert StallF, StallD and FlushE.
- 7. Otherwise all outputs are 0.
- A taken branch cannot coexist with mdv_opE, since both are in EX; mdv_opE wins by priority anyway.
- A mem_stall cannot occur in MDV_WAIT because MEM holds a bubble. If it is ever asserted there, it is ignored.
- stall_cycles increments on every cycle where StallF=1.

## Timing
- Stall*, Flush*, KillW and mdv_start are combinational from state and inputs (same-cycle effect).
- state and stall_cycles are registered.
- During reset=1:
  - All combinational outputs are forced to 0.
  - On the clock edge, state<=RUN and stall_cycles<=0.
  - Reset mid-MDV_WAIT or mid-MEM_WAIT aborts the wait without issuing a further mdv_start.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 (D and E flushed).
- A mul/div op with a done pulse N cycles after mdv_start stalls for N cycles. The done cycle itself does not stall.
- mdv_done is ignored outside MDV_WAIT. mdv_done in the same cycle as mdv_start is illegal; assert it in the bench.
- The mem wait stalls for as many cycles as dmem_ready is low.
- If a mem_stall and mdv_opE occur together, the mul/div issues on the first cycle after memory release.

## Test plan
- lw x5 in EX with Rs1D=5:
  - StallF=StallD=FlushE=1 for 1 cycle.
  - stall_cycles goes 0->1.
  - No stall follows with RdE=0.
- PCSrcE=1 with lu_haz also true:
  - FlushD=FlushE=1 and StallF=0 for exactly 1 cycle.
- mdv_opE=1, mdv_done pulsed 4 cycles after start:
  - mdv_start is high for the single cycle T0.
  - StallF/D/E and FlushM stay high T0..T3.
  - At T4 the stalls are low and state=RUN.
  - stall_cycles=4.
- dmem_reqM=1 with dmem_ready low for 3 cycles:
  - StallF/D/E/M and KillW are high for 3 cycles and state=MEM_WAIT.
  - On the 4th cycle all are low and state=RUN.
- mem_stall and mdv_opE together for 2 cycles:
  - No mdv_start during the wait.
  - mdv_start fires on the first released cycle.
- reset=1 asserted in MDV_WAIT:
  - All outputs are 0 during reset.
  - After reset, state=RUN and stall_cycles=0.
  - A late mdv_done has no effect.
